// File: rtl/rv_ram_responder_if.sv
// CPU data-RAM request/response bundle between rv_cpu and the memory-side responder.
interface rv_ram_responder_if;
    logic        ram_load;
    logic        ram_store;
    logic [2:0]  ram_funct3;
    logic [29:0] ram_address;
    logic [1:0]  ram_offset;
    logic [31:0] ram_store_value;
    logic        ram_stall;
    logic [31:0] ram_load_value;
    logic        ram_error;

    modport master (
        output ram_load, ram_store, ram_funct3, ram_address, ram_offset, ram_store_value,
        input  ram_stall, ram_load_value, ram_error
    );

    modport slave (
        input  ram_load, ram_store, ram_funct3, ram_address, ram_offset, ram_store_value,
        output ram_stall, ram_load_value, ram_error
    );
endinterface

// File: rtl/rv_ram_responder.sv
// Memory-side end of the CPU data-RAM port: byte/half/word loads and stores against a
// synchronous word SRAM with byte enables, stalling the CPU for WAIT_STATES+1 cycles.
module rv_ram_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset,
    rv_ram_responder_if.slave ram
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        reject;
        logic [1:0]  size;
        logic [29:0] addr;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } req_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    req_t            lat_q, lat_n;
    req_t            live_c, cur_c;
    logic            req_c;
    logic            done_entry_c;
    logic            wr_en_c;
    logic [3:0]      be_c;
    logic [AW-1:0]   idx_c;
    logic [31:0]     load_value_q;
    logic            error_q;
    logic [31:0]     mem [DEPTH];
    logic            unused_funct3_msb;

    assign unused_funct3_msb = ram.ram_funct3[2];
    assign req_c             = ram.ram_load | ram.ram_store;

    // Request as presented on the bus, with its reject decision.
    always_comb begin
        live_c        = '0;
        live_c.load   = ram.ram_load;
        live_c.store  = ram.ram_store;
        live_c.size   = ram.ram_funct3[1:0];
        live_c.addr   = ram.ram_address;
        live_c.offset = ram.ram_offset;
        live_c.wdata  = ram.ram_store_value;
        live_c.reject = (ram.ram_load & ram.ram_store)
                      | (ram.ram_funct3[1:0] == 2'b11)
                      | (ram.ram_address >= 30'(DEPTH))
                      | ((ram.ram_funct3[1:0] == 2'b01) & ram.ram_offset[0])
                      | ((ram.ram_funct3[1:0] == 2'b10) & (ram.ram_offset != 2'b00));
    end

    // With no wait states DONE is entered from the accept edge, so the live request is used.
    assign cur_c = (state_q == IDLE) ? live_c : lat_q;
    assign idx_c = cur_c.addr[AW-1:0];

    always_comb begin
        be_c = 4'b1111;
        case (cur_c.size)
            2'b00:   be_c = 4'b0001 << cur_c.offset;
            2'b01:   be_c = 4'b0011 << cur_c.offset;
            default: be_c = 4'b1111;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            lat_q   <= lat_n;
        end
    end

    // BUSY lasts WAIT_STATES cycles; the counter is preloaded one short to account for that.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        lat_n        = lat_q;
        done_entry_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    lat_n = live_c;
                    if (WAIT_STATES == 0) begin
                        state_n      = DONE;
                        done_entry_c = 1'b1;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CW'(WAIT_STATES - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CW'(1);
                end else begin
                    state_n      = DONE;
                    done_entry_c = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign wr_en_c = done_entry_c & cur_c.store & ~cur_c.reject & ~reset;

    // SRAM write lands on the DONE-entry edge, ahead of any later load's read.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= cur_c.wdata[8*b +: 8];
                end
            end
        end
    end

    // Response registers: populated only while in DONE, zero otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_value_q <= '0;
            error_q      <= 1'b0;
        end else if (done_entry_c) begin
            error_q      <= cur_c.reject;
            load_value_q <= (cur_c.load & ~cur_c.reject) ? mem[idx_c] : '0;
        end else if (state_q == DONE) begin
            load_value_q <= '0;
            error_q      <= 1'b0;
        end
    end

    assign ram.ram_stall      = ((state_q == IDLE) & req_c) | (state_q == BUSY);
    assign ram.ram_load_value = load_value_q;
    assign ram.ram_error      = error_q;
endmodule
